// File: rtl/nbit_muxn_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nbit_muxn_pipe_pkg: state encoding and select helpers for mux stages |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package nbit_muxn_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // Word-enable for slot idx; AND-OR of all slots gives the selected word.
  function automatic logic sel_word_en(input int unsigned sel, input int unsigned idx);
    return sel == idx;
  endfunction

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
    return sel < num_in;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nbit_muxn_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nbit_muxn_pipe_if: valid/ready bus plus flush for the registered mux |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface nbit_muxn_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [SEL_W-1:0]        in_sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;

  modport master (
    output flush, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel_err
  );

  modport slave (
    input  flush, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel_err
  );
endinterface
`default_nettype wire

// File: rtl/nbit_muxn_comb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nbit_muxn_comb: combinational N-way word select with range-error flag|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nbit_muxn_comb
  import nbit_muxn_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data,
  output logic [WIDTH-1:0]        word,
  output logic                    sel_err
);

  logic [WIDTH-1:0] w_masked [NUM_IN];

  // Masking every slot keeps unselected (possibly X) inputs off the result.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_slot
    assign w_masked[i] = data[i*WIDTH +: WIDTH] & {WIDTH{sel_word_en(int'(sel), i)}};
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      word = word | w_masked[i];
    end
  end

  assign sel_err = !sel_in_range(int'(sel), NUM_IN);

endmodule
`default_nettype wire

// File: rtl/nbit_muxn_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nbit_muxn_pipe: registered N-input word mux with 2-entry skid buffer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nbit_muxn_pipe
  import nbit_muxn_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic             clk,
  input logic             rst,
  nbit_muxn_pipe_if.slave bus
);

  logic [WIDTH-1:0] w_word;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_drain;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;

  nbit_muxn_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_comb (
    .sel     (bus.in_sel),
    .data    (bus.in_data),
    .word    (w_word),
    .sel_err (w_sel_err)
  );

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_drain  = r_out_valid && bus.out_ready;

  // in_ready and out_valid are flops tracking the state, so neither
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main_data <= w_word;
            r_main_err  <= w_sel_err;
            r_out_valid <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_accept && w_drain) begin
            r_main_data <= w_word;
            r_main_err  <= w_sel_err;
          end else if (w_accept) begin
            r_skid_data <= w_word;
            r_skid_err  <= w_sel_err;
            r_in_ready  <= 1'b0;
            r_state     <= ST_FULL;
          end else if (w_drain) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            r_main_data <= r_skid_data;
            r_main_err  <= r_skid_err;
            r_in_ready  <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_main_data;
  assign bus.out_sel_err = r_main_err;

endmodule
`default_nettype wire

// File: tb/tb_nbit_muxn_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nbit_muxn_pipe: scoreboard bench for the registered N-input mux   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_nbit_muxn_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  nbit_muxn_pipe_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
  nbit_muxn_pipe_if #(.WIDTH(8),  .NUM_IN(3)) bus3 ();

  nbit_muxn_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  nbit_muxn_pipe #(.WIDTH(8),  .NUM_IN(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  int checks = 0;
  int errors = 0;
  int pushes4 = 0;
  int pops4 = 0;

  logic [31:0] exp4_data;
  logic        exp4_err;
  logic [7:0]  exp3_data;
  logic        exp3_err;
  exp_t        q4[$];
  exp_t        q3[$];
  exp_t        e4, e3;
  logic        hold4 = 1'b0;
  logic [31:0] held4_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input int sel, input logic [31:0] d);
    bus4.in_valid = 1'b1;
    bus4.in_sel   = 2'(sel);
    exp4_data     = d;
    exp4_err      = 1'b0;
  endtask

  task automatic send3(input int sel, input logic [7:0] d, input logic err);
    bus3.in_valid = 1'b1;
    bus3.in_sel   = 2'(sel);
    exp3_data     = d;
    exp3_err      = err;
  endtask

  // Scoreboard for the 32-bit/4-input instance: pop on output transfer,
  // drop on flush/reset, push on accepted input.
  always @(negedge clk) begin
    if (!rst) begin
      q4.delete();
      hold4 = 1'b0;
    end else begin
      if (hold4 && bus4.out_valid)
        chk("dut4_hold_stable", 64'(bus4.out_data), 64'(held4_data));
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut4_unexpected_beat actual=%0h required=no_beat", bus4.out_data);
        end else begin
          e4 = q4.pop_front();
          pops4++;
          chk("dut4_data", 64'(bus4.out_data), 64'(e4.d));
          chk("dut4_err", 64'(bus4.out_sel_err), 64'(e4.e));
        end
      end
      hold4      = bus4.out_valid && !bus4.out_ready && !bus4.flush;
      held4_data = bus4.out_data;
      if (bus4.flush) begin
        q4.delete();
      end else if (bus4.in_valid && bus4.in_ready) begin
        e4.d = exp4_data;
        e4.e = exp4_err;
        q4.push_back(e4);
        pushes4++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      q3.delete();
    end else begin
      if (bus3.out_valid && bus3.out_ready) begin
        if (q3.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut3_unexpected_beat actual=%0h required=no_beat", bus3.out_data);
        end else begin
          e3 = q3.pop_front();
          chk("dut3_data", 64'(bus3.out_data), 64'(e3.d));
          chk("dut3_err", 64'(bus3.out_sel_err), 64'(e3.e));
        end
      end
      if (bus3.flush) begin
        q3.delete();
      end else if (bus3.in_valid && bus3.in_ready) begin
        e3.d = 32'(exp3_data);
        e3.e = exp3_err;
        q3.push_back(e3);
      end
    end
  end

  initial begin
    logic [127:0] rnd;
    int           beats;
    int           cyc;
    int           sel;
    logic         r_before;

    bus4.flush = 1'b0; bus4.in_valid = 1'b0; bus4.in_sel = '0; bus4.out_ready = 1'b1;
    bus4.in_data = {32'd8, 32'd7, 32'd6, 32'd5};
    bus3.flush = 1'b0; bus3.in_valid = 1'b0; bus3.in_sel = '0; bus3.out_ready = 1'b1;
    bus3.in_data = {8'd30, 8'd20, 8'd10};
    exp4_data = '0; exp4_err = 1'b0; exp3_data = '0; exp3_err = 1'b0;

    // Reset, then back-to-back selects with 1-cycle latency
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk("rst_in_ready", 64'(bus4.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus4.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus4.out_data), 64'd0);
    chk("rst_sel_err", 64'(bus4.out_sel_err), 64'd0);
    for (int i = 0; i < 4; i++) begin
      send4(i, 32'(5 + i));
      step();
      chk("lat_valid", 64'(bus4.out_valid), 64'd1);
      chk("lat_data", 64'(bus4.out_data), 64'(5 + i));
    end
    bus4.in_valid = 1'b0;
    step();
    chk("drain_empty", 64'(bus4.out_valid), 64'd0);

    // Back-pressure fills main then skid
    bus4.out_ready = 1'b0;
    send4(3, 32'd8);
    step();
    chk("bp_ready_busy", 64'(bus4.in_ready), 64'd1);
    send4(1, 32'd6);
    step();
    bus4.in_valid = 1'b0;
    chk("bp_ready_full", 64'(bus4.in_ready), 64'd0);
    chk("bp_head", 64'(bus4.out_data), 64'd8);
    step();
    chk("bp_held", 64'(bus4.out_data), 64'd8);
    bus4.out_ready = 1'b1;
    step();
    chk("bp_second", 64'(bus4.out_data), 64'd6);
    chk("bp_ready_back", 64'(bus4.in_ready), 64'd1);
    step();
    chk("bp_empty", 64'(bus4.out_valid), 64'd0);

    // Flush while FULL with a concurrent offer
    bus4.out_ready = 1'b0;
    send4(0, 32'd5);
    step();
    send4(1, 32'd6);
    step();
    bus4.flush = 1'b1;
    send4(2, 32'd7);
    step();
    bus4.flush = 1'b0;
    bus4.in_valid = 1'b0;
    chk("flush_full_valid", 64'(bus4.out_valid), 64'd0);
    chk("flush_full_ready", 64'(bus4.in_ready), 64'd1);
    // Flush while BUSY: in_ready is high, so the offer is dropped only by priority
    send4(0, 32'd5);
    step();
    bus4.flush = 1'b1;
    send4(2, 32'd7);
    step();
    bus4.flush = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    chk("flush_busy_valid", 64'(bus4.out_valid), 64'd0);
    step();
    step();
    chk("flush_no_ghost", 64'(bus4.out_valid), 64'd0);

    // Out-of-range select on the 3-input instance
    send3(3, 8'd0, 1'b1);
    step();
    chk("oor_data", 64'(bus3.out_data), 64'd0);
    chk("oor_err", 64'(bus3.out_sel_err), 64'd1);
    send3(2, 8'd30, 1'b0);
    step();
    chk("inr_data", 64'(bus3.out_data), 64'd30);
    chk("inr_err", 64'(bus3.out_sel_err), 64'd0);
    send3(0, 8'd10, 1'b0);
    step();
    chk("inr0_data", 64'(bus3.out_data), 64'd10);
    bus3.in_valid = 1'b0;
    step();

    // Reset while FULL discards both beats
    bus4.out_ready = 1'b0;
    send4(3, 32'd8);
    step();
    send4(2, 32'd7);
    step();
    bus4.in_valid = 1'b0;
    chk("pre_rst_full", 64'(bus4.in_ready), 64'd0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mid_rst_valid", 64'(bus4.out_valid), 64'd0);
    chk("mid_rst_data", 64'(bus4.out_data), 64'd0);
    chk("mid_rst_ready", 64'(bus4.in_ready), 64'd1);
    bus4.out_ready = 1'b1;
    step();
    step();
    chk("mid_rst_no_stale", 64'(bus4.out_valid), 64'd0);

    // Random stress: 1000 accepted beats with random valid/ready
    pushes4 = 0;
    pops4 = 0;
    beats = 0;
    cyc = 0;
    while (beats < 1000 && cyc < 20000) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      sel = int'($urandom_range(3, 0));
      bus4.in_data   = rnd;
      bus4.in_valid  = ($urandom_range(9, 0) < 7);
      bus4.in_sel    = 2'(sel);
      exp4_data      = rnd[sel*32 +: 32];
      exp4_err       = 1'b0;
      bus4.out_ready = ($urandom_range(9, 0) < 7);
      #1;
      r_before = bus4.in_ready;
      bus4.out_ready = ~bus4.out_ready;
      #1;
      chk("ready_indep", 64'(bus4.in_ready), 64'(r_before));
      bus4.out_ready = ~bus4.out_ready;
      @(negedge clk);
      if (bus4.in_valid && bus4.in_ready) beats++;
      cyc++;
      step();
    end
    chk("stress_beats", 64'(beats), 64'd1000);
    bus4.in_valid = 1'b0;
    bus4.out_ready = 1'b1;
    for (int i = 0; i < 50 && q4.size() != 0; i++) step();
    chk("stress_drained", 64'(q4.size()), 64'd0);
    chk("stress_count", 64'(pops4), 64'(pushes4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
